// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the EX stage (master) and the
// multi-cycle divider (slave).
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic               start_i;
    logic               signed_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;

    modport master (
        output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_unit.sv
// Restoring radix-2 divider for DIV/DIVU: one quotient bit per clock,
// result is {remainder, quotient}, sign-corrected on the final iteration.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DIVZERO = 2'd1;
    localparam logic [1:0] ON      = 2'd2;
    localparam logic [1:0] END     = 2'd3;

    logic [1:0]         state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [WIDTH-1:0]   rem_reg, rem_next;
    logic [WIDTH-1:0]   dvd_reg, dvd_next;
    logic [WIDTH-1:0]   dvs_reg, dvs_next;
    logic               neg_q_reg, neg_q_next;
    logic               neg_r_reg, neg_r_next;
    logic [2*WIDTH-1:0] result_reg, result_next;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     shifted, diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_step, q_step, q_fix, r_fix;

    assign a_neg = bus.signed_i & bus.opdata1_i[WIDTH-1];
    assign b_neg = bus.signed_i & bus.opdata2_i[WIDTH-1];
    assign abs_a = a_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    assign abs_b = b_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

    // shifted < 2*divisor always, so bit WIDTH of the difference is a clean borrow flag
    assign shifted  = {rem_reg, dvd_reg[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvs_reg};
    assign ge       = ~diff[WIDTH];
    assign rem_step = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign q_step   = {dvd_reg[WIDTH-2:0], ge};
    assign q_fix    = neg_q_reg ? (~q_step + 1'b1) : q_step;
    assign r_fix    = neg_r_reg ? (~rem_step + 1'b1) : rem_step;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rem_next    = rem_reg;
        dvd_next    = dvd_reg;
        dvs_next    = dvs_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_next = DIVZERO;
                        dvd_next   = bus.opdata1_i;
                    end else begin
                        state_next = ON;
                        dvd_next   = abs_a;
                        dvs_next   = abs_b;
                        neg_q_next = a_neg ^ b_neg;
                        neg_r_next = a_neg;
                        cnt_next   = '0;
                        rem_next   = '0;
                    end
                end
            end
            DIVZERO: begin
                if (bus.annul_i) begin
                    state_next = IDLE;
                end else begin
                    state_next  = END;
                    result_next = {dvd_reg, {WIDTH{1'b1}}};
                end
            end
            ON: begin
                // annul wins over completion on the same edge
                if (bus.annul_i) begin
                    state_next = IDLE;
                end else begin
                    dvd_next = q_step;
                    rem_next = rem_step;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        state_next  = END;
                        result_next = {r_fix, q_fix};
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            rem_reg    <= '0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rem_reg    <= rem_next;
            dvd_reg    <= dvd_next;
            dvs_reg    <= dvs_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            result_reg <= result_next;
        end
    end

    assign bus.result_o = result_reg;
    assign bus.ready_o  = (state_reg == END);
    assign bus.busy_o   = (state_reg == ON) || (state_reg == DIVZERO);
endmodule

// File: tb/tb_div_unit.sv
// Directed plus randomized bench for div_unit, checked against an arithmetic
// reference model of DIV/DIVU.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passes = 0;
    logic [63:0] last_res = 64'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one op, optionally fire a stray start mid-flight, and check
    // latency, busy profile, the ready pulse and the result.
    task automatic do_op(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input bit stray);
        logic [63:0] exp;
        int n;
        bit busy_ok;
        exp = model(s, a, b);
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.signed_i  = s;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        @(posedge clk); #1;
        bus.start_i   = 1'b0;
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
        bus.signed_i  = ~s;
        n = 0;
        busy_ok = 1'b1;
        while (!bus.ready_o && n < 100) begin
            if (!bus.busy_o) busy_ok = 1'b0;
            if (stray && n == 5) begin
                @(negedge clk);
                bus.start_i   = 1'b1;
                bus.opdata1_i = 32'd1000;
                bus.opdata2_i = 32'd3;
            end
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), (b == 32'h0) ? 64'd1 : 64'd32);
        chk({tag, "_busy_held"}, {63'h0, busy_ok}, 64'h1);
        chk({tag, "_busy_at_ready"}, {63'h0, bus.busy_o}, 64'h0);
        chk({tag, "_result"}, bus.result_o, exp);
        last_res = exp;
        @(posedge clk); #1;
        chk({tag, "_ready_drop"}, {63'h0, bus.ready_o}, 64'h0);
        $display("op %s s=%0b a=%h b=%h -> %h", tag, s, a, b, bus.result_o);
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;
        logic rs;

        bus.start_i   = 1'b0;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        bus.annul_i   = 1'b0;
        #1;
        chk("reset_busy", {63'h0, bus.busy_o}, 64'h0);
        chk("reset_ready", {63'h0, bus.ready_o}, 64'h0);
        chk("reset_result", bus.result_o, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        do_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, 1'b0);
        do_op("div_7_m2", 1'b1, 32'h7, 32'hFFFFFFFE, 1'b0);
        do_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        do_op("divu_min_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        do_op("divu_by0", 1'b0, 32'h1234, 32'h0, 1'b0);
        do_op("div_by0_neg", 1'b1, 32'hFFFF0000, 32'h0, 1'b0);

        // Annul at iteration 10: IDLE next edge, no ready, result held.
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_i = 1'b0;
        bus.opdata1_i = 32'd5000; bus.opdata2_i = 32'd9;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        chk("annul_busy", {63'h0, bus.busy_o}, 64'h0);
        seen = 0;
        repeat (40) begin
            if (bus.ready_o) seen++;
            @(posedge clk); #1;
        end
        chk("annul_no_ready", 64'(seen), 64'h0);
        chk("annul_result_held", bus.result_o, last_res);
        $display("op annul_iter10 result held %h", bus.result_o);

        do_op("stray_start", 1'b0, 32'd123456, 32'd77, 1'b1);

        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = ~32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            do_op($sformatf("rand%0d", i), rs, ra, rb, 1'b0);
        end

        // Asynchronous reset between edges, mid-iteration.
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_i = 1'b1;
        bus.opdata1_i = 32'd999; bus.opdata2_i = 32'd4;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", {63'h0, bus.busy_o}, 64'h0);
        chk("arst_ready", {63'h0, bus.ready_o}, 64'h0);
        chk("arst_result", bus.result_o, 64'h0);
        $display("op async_reset result %h", bus.result_o);
        @(negedge clk);
        rst = 1'b0;

        do_op("divu_9_3", 1'b0, 32'd9, 32'd3, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
